// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_pkg
//  Description : Shared PS/2 scan-code constants and fetch FSM encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package ps2_pkg;

    localparam logic [7:0] PS2_BRK = 8'hF0;
    localparam logic [7:0] PS2_EXT = 8'hE0;
    localparam logic [7:0] PS2_E1  = 8'hE1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_POP  = 2'd1,
        S_GAP  = 2'd2,
        S_PROC = 2'd3
    } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/ps2_held_table.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_held_table
//  Description : Held-key slot table with key lookup, lowest-free insert and
//                matched-slot removal.
//  Revision    : 1.0 - initial release
// ============================================================================
module ps2_held_table #(
    parameter int HELD_N = 2
) (
    input  logic                  clk,
    input  logic                  clrn,
    input  logic                  lookup_ext,
    input  logic [7:0]            lookup_code,
    input  logic                  insert_en,
    input  logic                  remove_en,
    output logic                  match,
    output logic                  full,
    output logic [HELD_N-1:0]     held_valid,
    output logic [HELD_N-1:0]     held_ext,
    output logic [8*HELD_N-1:0]   held_code
);

    logic [HELD_N-1:0] w_hit;
    logic [HELD_N-1:0] w_free;
    logic [HELD_N-1:0] w_first_free;

    for (genvar gi = 0; gi < HELD_N; gi++) begin : g_slot_hit
        assign w_hit[gi] = held_valid[gi] && (held_ext[gi] == lookup_ext) &&
                           (held_code[8*gi +: 8] == lookup_code);
    end

    assign match        = |w_hit;
    assign full         = &held_valid;
    assign w_free       = ~held_valid;
    // Isolate the lowest set bit of the free mask.
    assign w_first_free = w_free & (~w_free + HELD_N'(1));

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            held_valid <= '0;
            held_ext   <= '0;
            held_code  <= '0;
        end else begin
            for (int i = 0; i < HELD_N; i++) begin
                if (insert_en && !match && w_first_free[i]) begin
                    held_valid[i]      <= 1'b1;
                    held_ext[i]        <= lookup_ext;
                    held_code[8*i +: 8] <= lookup_code;
                end else if (remove_en && w_hit[i]) begin
                    held_valid[i] <= 1'b0;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/ps2_key_tracker.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_key_tracker
//  Description : Pops PS/2 bytes from a keyboard FIFO, parses E0/F0 prefixes
//                and tracks currently held keys, presses and repeats.
//  Revision    : 1.0 - initial release
// ============================================================================
module ps2_key_tracker
    import ps2_pkg::*;
#(
    parameter int HELD_N = 2,
    parameter int CNT_W  = 8
) (
    input  logic                  clk,
    input  logic                  clrn,
    input  logic [7:0]            kb_data,
    input  logic                  kb_ready,
    input  logic                  kb_overflow,
    output logic                  kb_nextdata_n,
    output logic [HELD_N-1:0]     held_valid,
    output logic [HELD_N-1:0]     held_ext,
    output logic [8*HELD_N-1:0]   held_code,
    output logic [7:0]            last_code,
    output logic                  last_ext,
    output logic [CNT_W-1:0]      press_count,
    output logic                  press_pulse,
    output logic                  repeat_pulse,
    output logic                  rollover,
    output logic                  ovf_seen
);

    fetch_state_t r_state;
    fetch_state_t w_state_nxt;
    logic [7:0]   r_byte;
    logic         r_ext_p;
    logic         r_brk_p;

    logic w_proc, w_is_key, w_make, w_break, w_ins;
    logic w_match, w_full;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (kb_ready) w_state_nxt = S_POP;
            S_POP:   w_state_nxt = S_GAP;
            S_GAP:   w_state_nxt = S_PROC;
            S_PROC:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_proc   = (r_state == S_PROC);
    assign w_is_key = w_proc && (r_byte != PS2_EXT) && (r_byte != PS2_BRK) && (r_byte != PS2_E1);
    assign w_make   = w_is_key && !r_brk_p;
    assign w_break  = w_is_key && r_brk_p;
    assign w_ins    = w_make && !w_match && !w_full;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_state       <= S_IDLE;
            kb_nextdata_n <= 1'b1;
            r_byte        <= '0;
            r_ext_p       <= 1'b0;
            r_brk_p       <= 1'b0;
            last_code     <= '0;
            last_ext      <= 1'b0;
            press_count   <= '0;
            press_pulse   <= 1'b0;
            repeat_pulse  <= 1'b0;
            rollover      <= 1'b0;
            ovf_seen      <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            // Strobe is registered from the next state so it is low exactly while in POP.
            kb_nextdata_n <= (w_state_nxt != S_POP);
            press_pulse   <= w_ins;
            repeat_pulse  <= w_make && w_match;
            ovf_seen      <= ovf_seen | kb_overflow;
            if (r_state == S_POP) begin
                r_byte <= kb_data;
            end
            if (w_proc) begin
                if (r_byte == PS2_EXT) begin
                    r_ext_p <= 1'b1;
                end else if (r_byte == PS2_BRK) begin
                    r_brk_p <= 1'b1;
                end else begin
                    r_ext_p <= 1'b0;
                    r_brk_p <= 1'b0;
                end
            end
            if (w_ins) begin
                press_count <= press_count + CNT_W'(1);
                last_code   <= r_byte;
                last_ext    <= r_ext_p;
            end
            if (w_make && !w_match && w_full) begin
                rollover <= 1'b1;
            end else if (w_break && w_match) begin
                rollover <= 1'b0;
            end
        end
    end

    ps2_held_table #(
        .HELD_N (HELD_N)
    ) u_table (
        .clk         (clk),
        .clrn        (clrn),
        .lookup_ext  (r_ext_p),
        .lookup_code (r_byte),
        .insert_en   (w_ins),
        .remove_en   (w_break),
        .match       (w_match),
        .full        (w_full),
        .held_valid  (held_valid),
        .held_ext    (held_ext),
        .held_code   (held_code)
    );

endmodule
`default_nettype wire

// File: tb/tb_ps2_key_tracker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ps2_key_tracker
//  Description : Self-checking bench for ps2_key_tracker with a FIFO model and
//                a slot-list reference model of the key tracker.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_key_tracker;

    localparam int HELD = 2;
    localparam int CW   = 4;

    logic              clk = 1'b0;
    logic              clrn = 1'b1;
    logic [7:0]        kb_data = 8'h00;
    logic              kb_ready = 1'b0;
    logic              kb_overflow = 1'b0;
    logic              kb_nextdata_n;
    logic [HELD-1:0]   held_valid;
    logic [HELD-1:0]   held_ext;
    logic [8*HELD-1:0] held_code;
    logic [7:0]        last_code;
    logic              last_ext;
    logic [CW-1:0]     press_count;
    logic              press_pulse;
    logic              repeat_pulse;
    logic              rollover;
    logic              ovf_seen;

    int errors = 0;
    int checks = 0;

    ps2_key_tracker #(.HELD_N(HELD), .CNT_W(CW)) dut (
        .clk           (clk),
        .clrn          (clrn),
        .kb_data       (kb_data),
        .kb_ready      (kb_ready),
        .kb_overflow   (kb_overflow),
        .kb_nextdata_n (kb_nextdata_n),
        .held_valid    (held_valid),
        .held_ext      (held_ext),
        .held_code     (held_code),
        .last_code     (last_code),
        .last_ext      (last_ext),
        .press_count   (press_count),
        .press_pulse   (press_pulse),
        .repeat_pulse  (repeat_pulse),
        .rollover      (rollover),
        .ovf_seen      (ovf_seen)
    );

    always #5 clk = ~clk;

    // Keyboard FIFO: pops on the edge that ends the strobe cycle, head re-driven just after.
    logic [7:0] fifo[$];
    always @(posedge clk) begin
        if (clrn && !kb_nextdata_n && fifo.size() > 0) void'(fifo.pop_front());
        #1;
        kb_ready = (fifo.size() > 0);
        kb_data  = (fifo.size() > 0) ? fifo[0] : 8'h00;
    end

    int viol = 0, press_seen = 0, rep_seen = 0;
    always @(negedge clk) begin
        if (clrn) begin
            if (!kb_nextdata_n && !kb_ready) viol++;
            if (press_pulse) press_seen++;
            if (repeat_pulse) rep_seen++;
        end
    end

    // Reference model: list of held keys plus prefix state.
    logic          m_valid[HELD];
    logic          m_ext[HELD];
    logic [7:0]    m_code[HELD];
    logic          m_extp, m_brkp, m_lastext, m_roll;
    logic [7:0]    m_last;
    logic [CW-1:0] m_count;
    int            m_press = 0, m_rep = 0;

    task automatic model_reset();
        for (int i = 0; i < HELD; i++) begin
            m_valid[i] = 1'b0; m_ext[i] = 1'b0; m_code[i] = 8'h00;
        end
        m_extp = 0; m_brkp = 0; m_lastext = 0; m_roll = 0; m_last = 8'h00; m_count = '0;
    endtask

    task automatic model_byte(input logic [7:0] b);
        int hit, free;
        if (b == 8'hE0) m_extp = 1'b1;
        else if (b == 8'hF0) m_brkp = 1'b1;
        else if (b == 8'hE1) begin m_extp = 1'b0; m_brkp = 1'b0; end
        else begin
            hit = -1;
            for (int i = 0; i < HELD; i++)
                if (m_valid[i] && m_ext[i] == m_extp && m_code[i] == b) hit = i;
            if (!m_brkp) begin
                if (hit >= 0) m_rep++;
                else begin
                    free = -1;
                    for (int i = HELD - 1; i >= 0; i--) if (!m_valid[i]) free = i;
                    if (free >= 0) begin
                        m_valid[free] = 1'b1; m_ext[free] = m_extp; m_code[free] = b;
                        m_count = m_count + 1'b1; m_last = b; m_lastext = m_extp; m_press++;
                    end else m_roll = 1'b1;
                end
            end else if (hit >= 0) begin
                m_valid[hit] = 1'b0; m_roll = 1'b0;
            end
            m_extp = 1'b0; m_brkp = 1'b0;
        end
    endtask

    task automatic push_byte(input logic [7:0] b);
        @(negedge clk);
        fifo.push_back(b);
        model_byte(b);
    endtask

    task automatic drain(input string nm);
        int t = 0;
        while (fifo.size() > 0 && t < 400) begin @(negedge clk); t++; end
        if (fifo.size() > 0) begin
            checks++; errors++;
            $display("FAIL %s drain_timeout got %0d bytes left, want 0", nm, fifo.size());
            fifo.delete();
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input string nm);
        push_byte(b);
        drain(nm);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        clrn = 1'b0;
        fifo.delete();
        model_reset();
        repeat (2) @(negedge clk);
        clrn = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        #3 clrn = 1'b0;
        #1;
        model_reset();
        repeat (2) @(negedge clk);
        clrn = 1'b1;
        repeat (2) @(negedge clk);
        send_byte(8'h1C, "reset_pre");
        send_byte(8'hE0, "reset_pre");
        @(posedge clk);
        #2 clrn = 1'b0;
        #1;
        checks++;
        if ({held_valid, held_ext, held_code} !== '0) begin
            errors++; $display("FAIL reset_table got %h/%h/%h want 0", held_valid, held_ext, held_code);
        end
        checks++;
        if ({last_code, last_ext, press_count, press_pulse, repeat_pulse, rollover, ovf_seen} !== '0) begin
            errors++; $display("FAIL reset_regs got last=%h ext=%b cnt=%0d pp=%b rp=%b ro=%b ovf=%b want 0",
                last_code, last_ext, press_count, press_pulse, repeat_pulse, rollover, ovf_seen);
        end
        checks++;
        if (kb_nextdata_n !== 1'b1) begin
            errors++; $display("FAIL reset_nextdata got %b want 1", kb_nextdata_n);
        end
        model_reset();
        @(negedge clk);
        clrn = 1'b1;
        repeat (2) @(negedge clk);
        send_byte(8'h75, "reset_post");
        checks++;
        if (held_valid !== 2'b01 || held_ext[0] !== 1'b0 || held_code[7:0] !== 8'h75) begin
            errors++; $display("FAIL reset_ext_discard got v=%b e=%b c=%h want v=01 e=0 c=75",
                held_valid, held_ext[0], held_code[7:0]);
        end
    endtask

    task automatic test_make_break();
        int p0;
        apply_reset();
        p0 = press_seen;
        send_byte(8'h1C, "mb");
        checks++;
        if (held_valid[0] !== 1'b1 || held_code[7:0] !== 8'h1C) begin
            errors++; $display("FAIL mb_hold got v=%b c=%h want 1/1C", held_valid[0], held_code[7:0]);
        end
        send_byte(8'hF0, "mb");
        send_byte(8'h1C, "mb");
        checks++;
        if (held_valid !== 2'b00 || press_count !== 4'd1 || press_seen - p0 !== 1) begin
            errors++; $display("FAIL mb_release got v=%b cnt=%0d pulses=%0d want 00/1/1",
                held_valid, press_count, press_seen - p0);
        end
    endtask

    task automatic test_repeat();
        int r0;
        apply_reset();
        r0 = rep_seen;
        for (int i = 0; i < 3; i++) send_byte(8'h1C, "rep");
        checks++;
        if (press_count !== 4'd1 || rep_seen - r0 !== 2 || held_valid !== 2'b01 || held_code[7:0] !== 8'h1C) begin
            errors++; $display("FAIL repeat got cnt=%0d reps=%0d v=%b c=%h want 1/2/01/1C",
                press_count, rep_seen - r0, held_valid, held_code[7:0]);
        end
    endtask

    task automatic test_extended();
        apply_reset();
        send_byte(8'hE0, "ext"); send_byte(8'h75, "ext");
        checks++;
        if (held_valid !== 2'b01 || held_ext[0] !== 1'b1 || held_code[7:0] !== 8'h75 || last_ext !== 1'b1) begin
            errors++; $display("FAIL ext_make got v=%b e=%b c=%h le=%b want 01/1/75/1",
                held_valid, held_ext[0], held_code[7:0], last_ext);
        end
        send_byte(8'h75, "ext");
        checks++;
        if (held_valid !== 2'b11 || held_ext[1] !== 1'b0 || held_code[15:8] !== 8'h75 || last_ext !== 1'b0) begin
            errors++; $display("FAIL ext_plain got v=%b e1=%b c1=%h le=%b want 11/0/75/0",
                held_valid, held_ext[1], held_code[15:8], last_ext);
        end
        send_byte(8'hE0, "ext"); send_byte(8'hF0, "ext"); send_byte(8'h75, "ext");
        checks++;
        if (held_valid !== 2'b10) begin
            errors++; $display("FAIL ext_break got v=%b want 10", held_valid);
        end
    endtask

    task automatic test_rollover();
        apply_reset();
        send_byte(8'h1C, "ro"); send_byte(8'h32, "ro"); send_byte(8'h21, "ro");
        checks++;
        if (rollover !== 1'b1 || press_count !== 4'd2) begin
            errors++; $display("FAIL ro_set got ro=%b cnt=%0d want 1/2", rollover, press_count);
        end
        send_byte(8'hF0, "ro"); send_byte(8'h1C, "ro");
        checks++;
        if (rollover !== 1'b0 || held_valid !== 2'b10 || held_code[15:8] !== 8'h32) begin
            errors++; $display("FAIL ro_clear got ro=%b v=%b c1=%h want 0/10/32", rollover, held_valid, held_code[15:8]);
        end
        send_byte(8'h21, "ro");
        checks++;
        if (held_valid !== 2'b11 || held_code[7:0] !== 8'h21 || press_count !== 4'd3) begin
            errors++; $display("FAIL ro_refill got v=%b c0=%h cnt=%0d want 11/21/3", held_valid, held_code[7:0], press_count);
        end
    endtask

    task automatic test_reset_prefix();
        apply_reset();
        send_byte(8'hF0, "rp");
        apply_reset();
        send_byte(8'h1C, "rp");
        checks++;
        if (held_valid !== 2'b01 || held_code[7:0] !== 8'h1C || press_count !== 4'd1) begin
            errors++; $display("FAIL brk_discard got v=%b c=%h cnt=%0d want 01/1C/1", held_valid, held_code[7:0], press_count);
        end
    endtask

    task automatic test_wrap();
        int p0, v0;
        logic [7:0] code;
        apply_reset();
        p0 = press_seen; v0 = viol;
        for (int i = 0; i < 16; i++) begin
            code = 8'h10 + 8'(i);
            push_byte(code); push_byte(8'hF0); push_byte(code);
            drain("wrap");
        end
        checks++;
        if (press_count !== 4'd0 || press_seen - p0 !== 16 || held_valid !== 2'b00) begin
            errors++; $display("FAIL wrap got cnt=%0d pulses=%0d v=%b want 0/16/00", press_count, press_seen - p0, held_valid);
        end
        checks++;
        if (viol - v0 !== 0) begin
            errors++; $display("FAIL pop_when_empty got %0d cycles want 0", viol - v0);
        end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        push_byte(8'h1C); push_byte(8'h32); push_byte(8'hF0); push_byte(8'h1C); push_byte(8'h21);
        drain("b2b");
        checks++;
        if (held_valid !== 2'b11 || held_code !== 16'h3221 || press_count !== 4'd3 || rollover !== 1'b0) begin
            errors++; $display("FAIL b2b got v=%b c=%h cnt=%0d ro=%b want 11/3221/3/0",
                held_valid, held_code, press_count, rollover);
        end
    endtask

    task automatic test_overflow();
        apply_reset();
        checks++;
        if (ovf_seen !== 1'b0) begin errors++; $display("FAIL ovf_idle got %b want 0", ovf_seen); end
        @(negedge clk) kb_overflow = 1'b1;
        @(negedge clk) kb_overflow = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (ovf_seen !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b want 1", ovf_seen); end
        apply_reset();
        checks++;
        if (ovf_seen !== 1'b0) begin errors++; $display("FAIL ovf_reset got %b want 0", ovf_seen); end
    endtask

    task automatic test_random();
        logic [7:0] pool[10];
        logic [7:0] b;
        pool = '{8'h1C, 8'h32, 8'h21, 8'h75, 8'hE0, 8'hF0, 8'hF0, 8'hE1, 8'h1C, 8'h32};
        apply_reset();
        for (int s = 0; s < 150; s++) begin
            b = pool[$urandom_range(0, 9)];
            push_byte(b);
            if ($urandom_range(0, 3) == 0) push_byte(pool[$urandom_range(0, 9)]);
            drain("rand");
            for (int i = 0; i < HELD; i++) begin
                checks++;
                if (held_valid[i] !== m_valid[i]) begin
                    errors++; $display("FAIL rand_valid[%0d] step %0d got %b want %b", i, s, held_valid[i], m_valid[i]);
                end
                if (m_valid[i]) begin
                    checks++;
                    if ({held_ext[i], held_code[8*i +: 8]} !== {m_ext[i], m_code[i]}) begin
                        errors++; $display("FAIL rand_slot[%0d] step %0d got %b/%h want %b/%h",
                            i, s, held_ext[i], held_code[8*i +: 8], m_ext[i], m_code[i]);
                    end
                end
            end
            checks++;
            if (press_count !== m_count || rollover !== m_roll || last_code !== m_last || last_ext !== m_lastext) begin
                errors++; $display("FAIL rand_regs step %0d got cnt=%0d ro=%b last=%b/%h want %0d/%b/%b/%h",
                    s, press_count, rollover, last_ext, last_code, m_count, m_roll, m_lastext, m_last);
            end
            checks++;
            if (press_seen !== m_press || rep_seen !== m_rep) begin
                errors++; $display("FAIL rand_pulses step %0d got p=%0d r=%0d want %0d/%0d",
                    s, press_seen, rep_seen, m_press, m_rep);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_make_break();
        test_repeat();
        test_extended();
        test_rollover();
        test_reset_prefix();
        test_wrap();
        test_back_to_back();
        test_overflow();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
